// File: rtl/hazard_md_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, the Tuse
// "not used" marker, MD scheduler states and the forward/stall helpers.
package hazard_md_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_W     = 2'd1;
  localparam logic [1:0] FWD_M     = 2'd2;
  localparam logic [1:0] FWD_E     = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } mdState_e;

  // Nearest producer whose value is already computed wins; $0 never forwards.
  function automatic logic [1:0] fwdSelect(
    input logic [4:0] src,
    input logic       rwE, input logic [4:0] wE, input logic [1:0] tnE,
    input logic       rwM, input logic [4:0] wM, input logic [1:0] tnM,
    input logic       rwW, input logic [4:0] wW
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (rwE && (wE == src) && (tnE == 2'd0))      sel = FWD_E;
      else if (rwM && (wM == src) && (tnM == 2'd0)) sel = FWD_M;
      else if (rwW && (wW == src))                  sel = FWD_W;
    end
    return sel;
  endfunction

  // Stall when a pending producer in E or M cannot deliver before the use.
  function automatic logic dataStall(
    input logic [4:0] src, input logic [1:0] tuse,
    input logic       rwE, input logic [4:0] wE, input logic [1:0] tnE,
    input logic       rwM, input logic [4:0] wM, input logic [1:0] tnM
  );
    logic hitE;
    logic hitM;
    hitE = rwE && (wE == src) && (tuse < tnE);
    hitM = rwM && (wM == src) && (tuse < tnM);
    return (src != 5'd0) && (tuse != TUSE_NONE) && (hitE || hitM);
  endfunction

endpackage

// File: rtl/hazard_md_ctrl_if.sv
// Pipeline-to-hazard-controller bundle. master = pipeline, slave = controller.
interface hazard_md_ctrl_if;
  logic [4:0]  rs_d;
  logic [4:0]  rt_d;
  logic [1:0]  tuse_rs_d;
  logic [1:0]  tuse_rt_d;
  logic        md_d;
  logic [4:0]  wreg_e;
  logic        regwrite_e;
  logic [1:0]  tnew_e;
  logic [4:0]  wreg_m;
  logic        regwrite_m;
  logic [1:0]  tnew_m;
  logic [4:0]  wreg_w;
  logic        regwrite_w;
  logic        md_start_e;
  logic        md_is_div_e;
  logic [1:0]  fwd_rs_d;
  logic [1:0]  fwd_rt_d;
  logic        stall;
  logic        md_busy;
  logic        md_done;
  logic [31:0] stall_cnt;

  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_d,
           wreg_e, regwrite_e, tnew_e, wreg_m, regwrite_m, tnew_m,
           wreg_w, regwrite_w, md_start_e, md_is_div_e,
    input  fwd_rs_d, fwd_rt_d, stall, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, md_d,
           wreg_e, regwrite_e, tnew_e, wreg_m, regwrite_m, tnew_m,
           wreg_w, regwrite_w, md_start_e, md_is_div_e,
    output fwd_rs_d, fwd_rt_d, stall, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_md_ctrl_md_sched.sv
// Multiply/divide occupancy scheduler: loads the op latency on start, counts
// down while busy and pulses mdDone for one cycle after the last busy cycle.
module hazard_md_ctrl_md_sched
  import hazard_md_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mdStart,
  input  logic mdIsDiv,
  output logic mdBusy,
  output logic mdDone
);

  mdState_e         state;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] loadVal;

  assign loadVal = mdIsDiv ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

  // FSM with latency counter; a start on the final busy cycle chains a new op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MD_IDLE;
      count  <= '0;
      mdBusy <= 1'b0;
      mdDone <= 1'b0;
    end else begin
      mdDone <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (mdStart) begin
            state  <= MD_BUSY;
            count  <= loadVal;
            mdBusy <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (count > CNT_W'(1)) begin
            count <= count - CNT_W'(1);
          end else begin
            mdDone <= 1'b1;
            if (mdStart) begin
              count <= loadVal;
            end else begin
              state  <= MD_IDLE;
              count  <= '0;
              mdBusy <= 1'b0;
            end
          end
        end
        default: begin
          state  <= MD_IDLE;
          count  <= '0;
          mdBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_md_ctrl.sv
// Hazard controller top: D-stage forwarding selects, data/MD stall and the
// stall-cycle performance counter, with MD scheduling in a sub-module.
module hazard_md_ctrl
  import hazard_md_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  hazard_md_ctrl_if.slave bus
);

  logic        mdBusy;
  logic        mdDone;
  logic        stallRs;
  logic        stallRt;
  logic        stallMd;
  logic        stallAll;
  logic [31:0] stallCnt;

  hazard_md_ctrl_md_sched #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) mdSched (
    .clk     (clk),
    .reset   (reset),
    .mdStart (bus.md_start_e),
    .mdIsDiv (bus.md_is_div_e),
    .mdBusy  (mdBusy),
    .mdDone  (mdDone)
  );

  // Zero-latency forwarding and stall decisions from the current pipeline view.
  always_comb begin
    bus.fwd_rs_d = fwdSelect(bus.rs_d,
                             bus.regwrite_e, bus.wreg_e, bus.tnew_e,
                             bus.regwrite_m, bus.wreg_m, bus.tnew_m,
                             bus.regwrite_w, bus.wreg_w);
    bus.fwd_rt_d = fwdSelect(bus.rt_d,
                             bus.regwrite_e, bus.wreg_e, bus.tnew_e,
                             bus.regwrite_m, bus.wreg_m, bus.tnew_m,
                             bus.regwrite_w, bus.wreg_w);
    stallRs  = dataStall(bus.rs_d, bus.tuse_rs_d,
                         bus.regwrite_e, bus.wreg_e, bus.tnew_e,
                         bus.regwrite_m, bus.wreg_m, bus.tnew_m);
    stallRt  = dataStall(bus.rt_d, bus.tuse_rt_d,
                         bus.regwrite_e, bus.wreg_e, bus.tnew_e,
                         bus.regwrite_m, bus.wreg_m, bus.tnew_m);
    stallMd  = bus.md_d && (bus.md_start_e || mdBusy);
    stallAll = stallRs || stallRt || stallMd;
  end

  // Count every edge at which the pipeline is held; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stallCnt <= '0;
    else if (stallAll) stallCnt <= stallCnt + 32'd1;
  end

  assign bus.stall     = stallAll;
  assign bus.md_busy   = mdBusy;
  assign bus.md_done   = mdDone;
  assign bus.stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Directed bench for hazard_md_ctrl with hand-computed expectations.
module tb_hazard_md_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  hazard_md_ctrl_if bus ();

  hazard_md_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.rs_d = 0; bus.rt_d = 0; bus.tuse_rs_d = 3; bus.tuse_rt_d = 3;
    bus.md_d = 0; bus.wreg_e = 0; bus.regwrite_e = 0; bus.tnew_e = 0;
    bus.wreg_m = 0; bus.regwrite_m = 0; bus.tnew_m = 0;
    bus.wreg_w = 0; bus.regwrite_w = 0;
    bus.md_start_e = 0; bus.md_is_div_e = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    #2;
    checks++; if (bus.md_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.md_busy); end
    checks++; if (bus.md_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.md_done); end
    checks++; if (bus.stall_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.stall_cnt); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_forward_priority();
    clear_inputs();
    bus.rs_d = 5; bus.rt_d = 5; bus.tuse_rs_d = 1; bus.tuse_rt_d = 1;
    bus.regwrite_e = 1; bus.wreg_e = 5; bus.tnew_e = 0;
    bus.regwrite_m = 1; bus.wreg_m = 5; bus.tnew_m = 0;
    bus.regwrite_w = 1; bus.wreg_w = 5;
    #1;
    checks++; if (bus.fwd_rs_d !== 2'd3) begin failures++; $display("FAIL fwd_rs_E got=%0d exp=3", bus.fwd_rs_d); end
    checks++; if (bus.fwd_rt_d !== 2'd3) begin failures++; $display("FAIL fwd_rt_E got=%0d exp=3", bus.fwd_rt_d); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL fwd_stall got=%0b exp=0", bus.stall); end
    bus.regwrite_e = 0;
    #1;
    checks++; if (bus.fwd_rs_d !== 2'd2) begin failures++; $display("FAIL fwd_rs_M got=%0d exp=2", bus.fwd_rs_d); end
    bus.regwrite_m = 0;
    #1;
    checks++; if (bus.fwd_rs_d !== 2'd1) begin failures++; $display("FAIL fwd_rs_W got=%0d exp=1", bus.fwd_rs_d); end
    bus.wreg_w = 6;
    #1;
    checks++; if (bus.fwd_rs_d !== 2'd0) begin failures++; $display("FAIL fwd_rs_RF got=%0d exp=0", bus.fwd_rs_d); end
    bus.regwrite_m = 1; bus.tnew_m = 1;
    #1;
    checks++; if (bus.fwd_rt_d !== 2'd0) begin failures++; $display("FAIL fwd_rt_Mnotready got=%0d exp=0", bus.fwd_rt_d); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.rs_d = 8; bus.tuse_rs_d = 0;
    bus.regwrite_e = 1; bus.wreg_e = 8; bus.tnew_e = 2;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL lu_E_stall got=%0b exp=1", bus.stall); end
    bus.tuse_rs_d = 3;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL lu_unused_stall got=%0b exp=0", bus.stall); end
    bus.tuse_rs_d = 0;
    bus.regwrite_e = 0; bus.regwrite_m = 1; bus.wreg_m = 8; bus.tnew_m = 1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL lu_M_stall got=%0b exp=1", bus.stall); end
    bus.tnew_m = 0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL lu_M_ready_stall got=%0b exp=0", bus.stall); end
    checks++; if (bus.fwd_rs_d !== 2'd2) begin failures++; $display("FAIL lu_M_fwd got=%0d exp=2", bus.fwd_rs_d); end
    bus.regwrite_e = 1; bus.tnew_e = 1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL lu_E_over_M_stall got=%0b exp=1", bus.stall); end
    bus.rs_d = 0; bus.rt_d = 8; bus.tuse_rt_d = 1; bus.tnew_e = 2;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL lu_rt_stall got=%0b exp=1", bus.stall); end
    bus.tuse_rt_d = 2;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL lu_rt_late_use got=%0b exp=0", bus.stall); end
  endtask

  task automatic test_reg_zero();
    clear_inputs();
    bus.rt_d = 0; bus.tuse_rt_d = 0;
    bus.regwrite_e = 1; bus.wreg_e = 0; bus.tnew_e = 2;
    #1;
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL r0_stall got=%0b exp=0", bus.stall); end
    checks++; if (bus.fwd_rt_d !== 2'd0) begin failures++; $display("FAIL r0_fwd got=%0d exp=0", bus.fwd_rt_d); end
    bus.tnew_e = 0;
    #1;
    checks++; if (bus.fwd_rt_d !== 2'd0) begin failures++; $display("FAIL r0_fwd_ready got=%0d exp=0", bus.fwd_rt_d); end
  endtask

  task automatic test_mult_mflo();
    clear_inputs();
    pulse_reset();
    step();
    bus.md_start_e = 1; bus.md_is_div_e = 0; bus.md_d = 1;
    #1;
    checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL mul_start_stall got=%0b exp=1", bus.stall); end
    checks++; if (bus.md_busy !== 1'b0) begin failures++; $display("FAIL mul_start_busy got=%0b exp=0", bus.md_busy); end
    step();
    bus.md_start_e = 0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      checks++; if (bus.md_busy !== 1'b1) begin failures++; $display("FAIL mul_busy c%0d got=%0b exp=1", i, bus.md_busy); end
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL mul_stall c%0d got=%0b exp=1", i, bus.stall); end
      checks++; if (bus.md_done !== 1'b0) begin failures++; $display("FAIL mul_early_done c%0d got=%0b exp=0", i, bus.md_done); end
      step();
    end
    #1;
    checks++; if (bus.md_done !== 1'b1) begin failures++; $display("FAIL mul_done got=%0b exp=1", bus.md_done); end
    checks++; if (bus.md_busy !== 1'b0) begin failures++; $display("FAIL mul_done_busy got=%0b exp=0", bus.md_busy); end
    checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL mul_done_stall got=%0b exp=0", bus.stall); end
    step();
    checks++; if (bus.md_done !== 1'b0) begin failures++; $display("FAIL mul_done_width got=%0b exp=0", bus.md_done); end
    checks++; if (bus.stall_cnt !== 32'd6) begin failures++; $display("FAIL mul_stall_cnt got=%0d exp=6", bus.stall_cnt); end
    bus.md_d = 0;
  endtask

  task automatic test_back_to_back();
    int busyCycles;
    int doneSeen;
    clear_inputs();
    pulse_reset();
    step();
    bus.md_start_e = 1; bus.md_is_div_e = 0;
    step();
    bus.md_start_e = 0;
    for (int i = 1; i <= 4; i++) step();
    #1;
    checks++; if (bus.md_busy !== 1'b1) begin failures++; $display("FAIL b2b_last_busy got=%0b exp=1", bus.md_busy); end
    bus.md_start_e = 1; bus.md_is_div_e = 1;
    step();
    bus.md_start_e = 0; bus.md_is_div_e = 0;
    #1;
    checks++; if (bus.md_done !== 1'b1) begin failures++; $display("FAIL b2b_mul_done got=%0b exp=1", bus.md_done); end
    busyCycles = 0;
    doneSeen = 0;
    for (int i = 0; i < 14; i++) begin
      if (bus.md_busy === 1'b1) busyCycles++;
      if (i > 0 && i < 10 && bus.md_done === 1'b1) doneSeen++;
      step();
    end
    checks++; if (busyCycles !== 10) begin failures++; $display("FAIL b2b_div_busy got=%0d exp=10", busyCycles); end
    checks++; if (doneSeen !== 0) begin failures++; $display("FAIL b2b_extra_done got=%0d exp=0", doneSeen); end
    checks++; if (bus.stall_cnt !== 32'd0) begin failures++; $display("FAIL b2b_stall_cnt got=%0d exp=0", bus.stall_cnt); end
  endtask

  task automatic test_reset_mid_div();
    int doneSeen;
    int busySeen;
    clear_inputs();
    pulse_reset();
    step();
    bus.md_start_e = 1; bus.md_is_div_e = 1; bus.md_d = 1;
    step();
    bus.md_start_e = 0; bus.md_is_div_e = 0;
    step();
    step();
    checks++; if (bus.stall_cnt !== 32'd3) begin failures++; $display("FAIL rmd_pre_cnt got=%0d exp=3", bus.stall_cnt); end
    checks++; if (bus.md_busy !== 1'b1) begin failures++; $display("FAIL rmd_pre_busy got=%0b exp=1", bus.md_busy); end
    bus.md_d = 0;
    #1;
    reset = 1'b1;
    #1;
    checks++; if (bus.md_busy !== 1'b0) begin failures++; $display("FAIL rmd_busy got=%0b exp=0", bus.md_busy); end
    checks++; if (bus.stall_cnt !== 32'd0) begin failures++; $display("FAIL rmd_cnt got=%0d exp=0", bus.stall_cnt); end
    step();
    reset = 1'b0;
    doneSeen = 0;
    busySeen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.md_done === 1'b1) doneSeen++;
      if (bus.md_busy === 1'b1) busySeen++;
    end
    checks++; if (doneSeen !== 0) begin failures++; $display("FAIL rmd_done got=%0d exp=0", doneSeen); end
    checks++; if (busySeen !== 0) begin failures++; $display("FAIL rmd_busy_after got=%0d exp=0", busySeen); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_forward_priority();
    test_load_use();
    test_reg_zero();
    test_mult_mflo();
    test_back_to_back();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
